// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
//
// Multi-channel PWM generator. A single time-base counter is shared by all
// channels. It counts either up (edge-aligned) or up-down (center-aligned).
// The period and the per-channel compare values are double-buffered. Writes
// land in shadow registers, and those values move into the active registers
// only at period boundaries (upd). Each channel drives a complementary pair.
//
// Optional feature (compile-time macro PWM_DEADBAND_EN):
//   When the macro is defined, every transition of a channel's raw compare
//   output is followed by db_cycles clocks during which both outputs of that
//   pair are low. A raw pulse shorter than the dead band is swallowed. When
//   the macro is undefined, the outputs are the registered raw value and its
//   complement, db_cycles is ignored, and no dead-band logic is built.
//
// Parameters:
//   WIDTH      counter / period / compare width
//   CHANNELS   number of compare channels (output pairs)
//   PRD_RESET  reset value of the shadow and active period
//   CMP_RESET  reset value of every shadow and active compare
//   DB_WIDTH   width of the dead-band delay count
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   en         count enable; when low, counter, direction and outputs hold
//   mode       0 = up count, 1 = up-down count
//   sync_load  loads sync_val into the counter on the next edge (dir = up)
//   sync_val   counter value used by sync_load
//   prd_wr     writes prd_data into the period shadow
//   prd_data   period shadow data
//   cmp_wr     per-channel compare shadow write strobes
//   cmp_data   compare shadow data, shared by all channels
//   db_cycles  dead-band delay in clocks (used only with PWM_DEADBAND_EN)
//   cnt        current counter value
//   ctr_zero   cnt == 0
//   ctr_prd    cnt == active period
//   upd        high in the cycle whose edge moves shadows into active
//   pwm_a      high-side outputs
//   pwm_b      low-side (complementary) outputs
// -----------------------------------------------------------------------------
module pwm_multi_channel #(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned PRD_RESET = 1000,
  parameter int unsigned CMP_RESET = 20,
  parameter int unsigned DB_WIDTH  = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                mode,
  input  logic                sync_load,
  input  logic [WIDTH-1:0]    sync_val,
  input  logic                prd_wr,
  input  logic [WIDTH-1:0]    prd_data,
  input  logic [CHANNELS-1:0] cmp_wr,
  input  logic [WIDTH-1:0]    cmp_data,
  input  logic [DB_WIDTH-1:0] db_cycles,
  output logic [WIDTH-1:0]    cnt,
  output logic                ctr_zero,
  output logic                ctr_prd,
  output logic                upd,
  output logic [CHANNELS-1:0] pwm_a,
  output logic [CHANNELS-1:0] pwm_b
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0] PRD_INIT = WIDTH'(PRD_RESET);
  localparam logic [WIDTH-1:0] CMP_INIT = WIDTH'(CMP_RESET);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]    cnt_q;
  logic [WIDTH-1:0]    cnt_d;
  dir_t                dir_q;
  dir_t                dir_d;
  // Set by reset. It makes the first counting edge at cnt == 0 an update
  // edge, so the shadows written before the first enable become active
  // immediately instead of one full period later.
  logic                init_pend_q;

  logic [WIDTH-1:0]    prd_shd;
  logic [WIDTH-1:0]    prd_act;
  logic [WIDTH-1:0]    cmp_shd [CHANNELS];
  logic [WIDTH-1:0]    cmp_act [CHANNELS];

  logic [CHANNELS-1:0] raw;

  // ---------------------------------------------------------------------------
  // Time-base next state
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top.
  // That way, no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (sync_load) begin
      // A sync load wins over counting and ignores en.
      cnt_d = sync_val;
      dir_d = DIR_UP;
    end else if (en) begin
      if (!mode) begin
        // Up mode. Also recovers at once from cnt > prd_act after a period
        // shrink or a sync load beyond the period.
        dir_d = DIR_UP;
        cnt_d = (cnt_q >= prd_act) ? '0 : cnt_q + ONE;
      end else if (cnt_q > prd_act) begin
        // Up-down mode while above the period: head down toward it.
        dir_d = DIR_DOWN;
        cnt_d = cnt_q - ONE;
      end else if (dir_q == DIR_UP) begin
        if (cnt_q == prd_act) begin
          // Turn around at the top. With prd_act == 0 the counter stays at 0.
          dir_d = DIR_DOWN;
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          // Turn around at the bottom.
          dir_d = DIR_UP;
          cnt_d = (prd_act == '0) ? '0 : ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      dir_q       <= DIR_UP;
      init_pend_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      if (upd) begin
        init_pend_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status decodes (combinational on registered state)
  // ---------------------------------------------------------------------------
  assign cnt      = cnt_q;
  assign ctr_zero = (cnt_q == '0);
  assign ctr_prd  = (cnt_q == prd_act);
  assign upd      = en & ~sync_load &
                    ((~mode & (cnt_q == prd_act)) |
                     ( mode & (cnt_q == '0) & (dir_q == DIR_DOWN)) |
                     (init_pend_q & (cnt_q == '0)));

  // ---------------------------------------------------------------------------
  // Shadow and active period / compare registers
  // ---------------------------------------------------------------------------
  // The active registers sample the shadows before this edge's write. A write
  // coinciding with upd therefore reaches the active copy only one period
  // later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prd_shd <= PRD_INIT;
      prd_act <= PRD_INIT;
    end else begin
      if (prd_wr) begin
        prd_shd <= prd_data;
      end
      if (upd) begin
        prd_act <= prd_shd;
      end
    end
  end

  // NOTE: these register arrays are reset explicitly. They are a few flops
  // that must restart at defined compare values, not RAM, so no reset-less
  // memory inference is wanted here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        cmp_shd[i] <= CMP_INIT;
        cmp_act[i] <= CMP_INIT;
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (cmp_wr[i]) begin
          cmp_shd[i] <= cmp_data;
        end
        if (upd) begin
          cmp_act[i] <= cmp_shd[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Raw compare: high while the counter is below the channel's compare value.
  // cmp == 0 never fires; cmp > prd_act is always high.
  // ---------------------------------------------------------------------------
  always_comb begin
    raw = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      raw[i] = (cnt_q < cmp_act[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef PWM_DEADBAND_EN
  logic [CHANNELS-1:0] raw_q;
  logic [DB_WIDTH-1:0] db_cnt [CHANNELS];

  // A raw transition drives both outputs low and loads db_cnt with db_cycles.
  // The pair stays low until db_cnt has counted down to 1. On that edge the
  // side matching raw turns on. A new transition inside the window restarts
  // it, which swallows pulses shorter than the dead band.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw_q <= '0;
      pwm_a <= '0;
      pwm_b <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        db_cnt[i] <= '0;
      end
    end else if (en) begin
      raw_q <= raw;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (raw[i] != raw_q[i]) begin
          if (db_cycles == '0) begin
            pwm_a[i]  <= raw[i];
            pwm_b[i]  <= ~raw[i];
            db_cnt[i] <= '0;
          end else begin
            pwm_a[i]  <= 1'b0;
            pwm_b[i]  <= 1'b0;
            db_cnt[i] <= db_cycles;
          end
        end else if (db_cnt[i] > DB_WIDTH'(1)) begin
          pwm_a[i]  <= 1'b0;
          pwm_b[i]  <= 1'b0;
          db_cnt[i] <= db_cnt[i] - DB_WIDTH'(1);
        end else begin
          pwm_a[i]  <= raw[i];
          pwm_b[i]  <= ~raw[i];
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  // Without dead band: one register stage, complementary pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_a <= '0;
      pwm_b <= '0;
    end else if (en) begin
      pwm_a <= raw;
      pwm_b <= ~raw;
    end
  end

  // db_cycles has no function in this build.
  logic unused_db;
  assign unused_db = ^db_cycles;
`endif

endmodule

// File: tb/tb_pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_channel
//
// Directed bench for pwm_multi_channel with default parameters (WIDTH 12,
// CHANNELS 2, PRD_RESET 1000, CMP_RESET 20). Expected values are written out
// by hand per step. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_pwm_multi_channel;

  logic        clock;
  logic        reset;
  logic        en;
  logic        mode;
  logic        sync_load;
  logic [11:0] sync_val;
  logic        prd_wr;
  logic [11:0] prd_data;
  logic [1:0]  cmp_wr;
  logic [11:0] cmp_data;
  logic [7:0]  db_cycles;
  logic [11:0] cnt;
  logic        ctr_zero;
  logic        ctr_prd;
  logic        upd;
  logic [1:0]  pwm_a;
  logic [1:0]  pwm_b;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Up mode, PRD 4, cmp 2/2, starting from the first (init) update edge.
  int up_cnt [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
  int up_a0  [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
  // cmp[0] shadow 3 written mid-period: duty 2/5 -> 3/5; cmp[1] stays 2/5.
  int mw_cnt [9]  = '{2, 3, 4, 0, 1, 2, 3, 4, 0};
  int mw_a0  [9]  = '{1, 0, 0, 0, 1, 1, 1, 0, 0};
  int mw_a1  [9]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
  // cmp[0] shadow 1 written on the upd edge: 3/5 kept for one period, then 1/5.
  int uw_a0  [10] = '{1, 1, 1, 0, 0, 1, 0, 0, 0, 0};
  // Up-down mode, PRD 4, cmp[1] 2.
  int ud_cnt [16] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0};
  int ud_a1  [16] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
  int ud_upd [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
  int ud_prd [16] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
`ifdef PWM_DEADBAND_EN
  // Dead band 2, PRD 9, cmp 5, samples at cnt 0..9 then 0.
  int db_a0  [11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
  int db_b0  [11] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
`endif

  pwm_multi_channel dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .sync_load (sync_load),
    .sync_val  (sync_val),
    .prd_wr    (prd_wr),
    .prd_data  (prd_data),
    .cmp_wr    (cmp_wr),
    .cmp_data  (cmp_data),
    .db_cycles (db_cycles),
    .cnt       (cnt),
    .ctr_zero  (ctr_zero),
    .ctr_prd   (ctr_prd),
    .upd       (upd),
    .pwm_a     (pwm_a),
    .pwm_b     (pwm_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    mode      = 1'b0;
    sync_load = 1'b0;
    sync_val  = '0;
    prd_wr    = 1'b0;
    prd_data  = '0;
    cmp_wr    = '0;
    cmp_data  = '0;
    db_cycles = '0;

    // Reset state.
    #12;
    check("rst_cnt",   cnt,      0);
    check("rst_pwm_a", pwm_a,    0);
    check("rst_pwm_b", pwm_b,    0);
    check("rst_zero",  ctr_zero, 1);
    check("rst_prd",   ctr_prd,  0);
    check("rst_upd",   upd,      0);
    #1 reset = 1'b0;

    // Load shadows with en low: PRD 4, both compares 2.
    prd_wr = 1'b1; prd_data = 12'd4;
    cmp_wr = 2'b11; cmp_data = 12'd2;
    tick();
    prd_wr = 1'b0; cmp_wr = 2'b00;
    check("hold_cnt", cnt, 0);
    en = 1'b1;
    #1;
    check("init_upd", upd, 1);

    // Up mode.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("up_cnt",  cnt,      up_cnt[i]);
      check("up_a0",   pwm_a[0], up_a0[i]);
      check("up_b0",   pwm_b[0], 1 - up_a0[i]);
      check("up_prd",  ctr_prd,  (up_cnt[i] == 4) ? 1 : 0);
      check("up_upd",  upd,      (up_cnt[i] == 4) ? 1 : 0);
    end

    // Mid-period compare write.
    cmp_wr = 2'b01; cmp_data = 12'd3;
    tick();
    cmp_wr = 2'b00;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("mw_cnt", cnt,      mw_cnt[i]);
      check("mw_a0",  pwm_a[0], mw_a0[i]);
      check("mw_a1",  pwm_a[1], mw_a1[i]);
    end

    // Compare write on the update edge itself.
    repeat (4) tick();
    check("uw_cnt4", cnt, 4);
    check("uw_upd",  upd, 1);
    cmp_wr = 2'b01; cmp_data = 12'd1;
    tick();
    cmp_wr = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("uw_a0", pwm_a[0], uw_a0[i]);
    end

    // Up-down mode.
    mode = 1'b1;
    #1;
    check("ud_upd_dirup", upd, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("ud_cnt", cnt,      ud_cnt[i]);
      check("ud_a1",  pwm_a[1], ud_a1[i]);
      check("ud_upd", upd,      ud_upd[i]);
      check("ud_prd", ctr_prd,  ud_prd[i]);
    end

    // Compare boundaries: cmp[0] = 0, cmp[1] = 5 > PRD 4.
    mode = 1'b0;
    cmp_wr = 2'b01; cmp_data = 12'd0;
    tick();
    cmp_wr = 2'b10; cmp_data = 12'd5;
    tick();
    cmp_wr = 2'b00;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bnd_a", pwm_a, 2'b10);
      check("bnd_b", pwm_b, 2'b01);
    end

    // Sync load with en low.
    en = 1'b0;
    sync_load = 1'b1; sync_val = 12'd3;
    #1;
    check("sync_upd_lo", upd, 0);
    tick();
    sync_load = 1'b0;
    check("sync_cnt", cnt,   3);
    check("sync_pwm", pwm_a, 2'b10);
    repeat (2) tick();
    check("en_hold_cnt", cnt, 3);
    en = 1'b1;
    tick();
    check("sync_cnt4", cnt, 4);
    check("sync_upd4", upd, 1);
    sync_load = 1'b1; sync_val = 12'd2;
    #1;
    check("sync_upd_sup", upd, 0);
    tick();
    sync_load = 1'b0;
    check("sync_cnt2", cnt, 2);

    // Reset mid-count with PRD 9.
    prd_wr = 1'b1; prd_data = 12'd9;
    tick();
    prd_wr = 1'b0;
    tick();
    check("pre_cnt4", cnt, 4);
    tick();
    repeat (7) tick();
    check("pre_cnt7",   cnt,   7);
    check("pre_pwm_b",  pwm_b, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("arst_cnt",   cnt,   0);
    check("arst_pwm_a", pwm_a, 0);
    check("arst_pwm_b", pwm_b, 0);
    tick();
    reset = 1'b0;
    #1;
    check("arst_init_upd", upd, 1);

    // Period and compare return to 1000 / 20.
    for (int k = 1; k <= 1001; k++) begin
      tick();
      if (k == 20) begin
        check("rv_a_19", pwm_a, 2'b11);
      end
      if (k == 21) begin
        check("rv_a_20", pwm_a, 2'b00);
        check("rv_b_20", pwm_b, 2'b11);
      end
      if (k == 1000) begin
        check("rv_cnt1000", cnt,     1000);
        check("rv_prd1000", ctr_prd, 1);
        check("rv_upd1000", upd,     1);
      end
      if (k == 1001) begin
        check("rv_wrap", cnt, 0);
      end
    end

`ifdef PWM_DEADBAND_EN
    // Dead band 2, PRD 9, cmp 5.
    en = 1'b0;
    db_cycles = 8'd2;
    prd_wr = 1'b1; prd_data = 12'd9;
    cmp_wr = 2'b11; cmp_data = 12'd5;
    sync_load = 1'b1; sync_val = 12'd1000;
    tick();
    prd_wr = 1'b0; cmp_wr = 2'b00; sync_load = 1'b0;
    en = 1'b1;
    #1;
    check("db_upd", upd, 1);
    for (int i = 0; i < 11; i++) begin
      tick();
      check("db_a0", pwm_a[0], db_a0[i]);
      check("db_b0", pwm_b[0], db_b0[i]);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator: one shared time-base counter with up or up-down (center-aligned) counting, a shadowed period register, and CHANNELS shadowed compare registers. Each channel drives a complementary output pair. It replaces the fixed 12-bit single-channel PWM datapath in the motor/power-stage control path. Software-side writes go to shadow registers, which take effect only at period boundaries.

## Interface
- WIDTH, 12, width of counter, period and compare values
- CHANNELS, 2, number of compare channels / output pairs
- PRD_RESET, 1000, reset value of shadow and active period
- CMP_RESET, 20, reset value of every shadow and active compare
- DB_WIDTH, 8, width of dead-band cycle count
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- en  in  1  count enable; low holds counter, direction and outputs
- mode  in  1  0 = up count, 1 = up-down count
- sync_load  in  1  force counter to sync_val on next edge
- sync_val  in  WIDTH  value loaded by sync_load
- prd_wr  in  1  write prd_data into period shadow
- prd_data  in  WIDTH  period shadow data
- cmp_wr  in  CHANNELS  per-channel compare shadow write strobe
- cmp_data  in  WIDTH  compare shadow data, shared by all channels
- db_cycles  in  DB_WIDTH  dead-band delay in clocks
- cnt  out  WIDTH  current counter value
- ctr_zero  out  1  high while cnt == 0
- ctr_prd  out  1  high while cnt == active period
- upd  out  1  high in the cycle whose edge transfers shadows to active
- pwm_a  out  CHANNELS  high-side outputs
- pwm_b  out  CHANNELS  low-side (complementary) outputs

## Operation
- Reset: cnt=0, dir=up, shadow and active period=PRD_RESET, shadow and active compares=CMP_RESET, pwm_a=0, pwm_b=0, dead-band counters=0.
- Up mode: cnt counts 0..prd_act, then wraps to 0. Period = prd_act+1 clocks.
- Up-down mode: cnt counts up to prd_act, dir flips to down, counts to 0, then dir flips to up. Period = 2*prd_act clocks. With prd_act=0, cnt stays at 0.
- Switching mode mid-period takes effect immediately. If cnt > prd_act in up mode, the next value is 0. In up-down mode, cnt > prd_act forces dir=down.
- upd = en & ~sync_load & ((mode==0 & cnt==prd_act) | (mode==1 & cnt==0 & dir==down)). Also asserted on the first edge with cnt==0 after reset.
- On an upd edge, the active period and all active compares are loaded from their shadows.
- A shadow write on the same edge as upd: the new value goes to the shadow only. It becomes active at the next upd.
- sync_load has priority over counting. On that edge, cnt=sync_val and dir=up, regardless of en. No upd is generated that cycle.
- Raw channel output: raw[i] = (cnt < cmp_act[i]), unsigned compare.
  - cmp=0 gives raw constantly low.
  - cmp > prd_act gives raw constantly high.
- ctr_zero, ctr_prd and upd are combinational decodes of registered state.

## Timing
- pwm_a/pwm_b are registered, one clock after the cnt value that produced raw.
- Shadow write to active: at the first upd edge after the write edge.
- en low: cnt, dir, pwm outputs and dead-band counters all hold. Shadow writes are still accepted.
- Reset assertion mid-period returns all state to reset values immediately, asynchronously.

## Configuration
- Macro: PWM_DEADBAND_EN.
- Defined:
  - A rising edge of raw[i] is delayed by db_cycles clocks before pwm_a[i] rises. pwm_b[i] falls on the same edge raw rises, so both outputs are low during the dead band.
  - A falling edge of raw is delayed by db_cycles before pwm_b[i] rises. pwm_a[i] falls immediately.
  - A raw pulse shorter than db_cycles produces no pulse on that output.
  - db_cycles=0 is equivalent to the undefined behaviour.
- Undefined: pwm_a = raw and pwm_b = ~raw, registered. db_cycles is ignored, and no dead-band logic is present.

## Test plan
- Up mode, PRD shadow=4, cmp[0]=2, after upd: cnt 0,1,2,3,4,0 repeating, and pwm_a[0] high 2 of 5 clocks, one clock after cnt. Check that ctr_prd pulses at cnt=4.
- Up-down mode, PRD=4, cmp[1]=2: cnt 0,1,2,3,4,3,2,1,0, period 8, and pwm_a[1] high for cnt 0,1,1,0 (center-aligned). Check that upd fires only at cnt=0 with dir=down.
- Write cmp[0]=3 mid-period in up mode, PRD=4: pwm_a duty stays 2/5 until the next wrap, then becomes 3/5. Write on the upd edge itself: duty changes only one period later.
- cmp=0 gives pwm_a constantly 0 and pwm_b constantly 1. cmp=5 with PRD=4 gives pwm_a constantly 1. Check that sync_load with sync_val=3 gives cnt=3 next clock with no upd, even with en low.
- PWM_DEADBAND_EN, db_cycles=2, PRD=9, cmp=5: every raw edge is followed by 2 clocks with both outputs low. pwm_a is high 3 clocks and pwm_b high 3 clocks per period.
- Assert reset mid-count with cnt=7: cnt=0, pwm_a=0 and pwm_b=0 immediately, and period/compare return to 1000/20.
